gaussian_blur_stream: RTL
=========================

// Module: gaussian_blur_stream
// PURPOSE
// Streaming 2D convolution stage directly downstream of the Gaussian kernel generator. Loads a
// SIZE x SIZE fixed-point kernel once, then filters a raster-order grayscale pixel stream through
// SIZE-1 line buffers and a sliding window. Emits only fully-covered ("valid") window positions,
// an (IMG_W-SIZE+1) x (IMG_H-SIZE+1) image, to the gradient/edge stage. Uses valid/ready handshakes.
// PARAMETERS
// SIZE      5   kernel edge length; odd, 3..7
// IMG_W     64  frame width in pixels; >= SIZE
// IMG_H     64  frame height in pixels; >= SIZE
// PIX_W     8   pixel width, unsigned
// COEF_W    16  coefficient width, unsigned
// COEF_FRAC 14  coefficient fraction bits (1.0 = 2**COEF_FRAC)
// PORTS
// clk        in   1      clock; all logic on rising edge
// reset      in   1      synchronous, active-high reset
// coef_valid in   1      coefficient offered
// coef_ready out  1      coefficient accepted when valid & ready
// coef_data  in   COEF_W coefficient, raster order k[0][0]..k[SIZE-1][SIZE-1]
// reload     in   1      request a new kernel load; sampled only at a frame boundary
// in_valid   in   1      input pixel offered
// in_ready   out  1      input pixel accepted when valid & ready
// in_pixel   in   PIX_W  input pixel, raster order
// out_valid  out  1      filtered pixel available
// out_ready  in   1      downstream accepts when valid & ready
// out_pixel  out  PIX_W  filtered pixel
// frame_done out  1      one-cycle pulse, last output pixel of a frame accepted
// BEHAVIOUR
// - Reset: state=LOAD, coef count=0, row=col=0, coef_ready=1, in_ready=0, out_valid=0,
//   out_pixel=0, frame_done=0. Line-buffer contents are don't-care; coefficients are cleared to 0.
// - FSM LOAD: coef_ready=1. On each handshake, coef[idx] <= coef_data and idx++.
//   After SIZE*SIZE handshakes, go to RUN with idx=0. in_ready=0 in LOAD.
// - FSM RUN: coef_ready=0, coef_valid is ignored. in_ready = !out_valid || out_ready.
//   This is a single-entry output register with pass-through when drained.
// - On an accepted pixel: shift it into the window and line buffers, then advance col.
//   col wraps at IMG_W-1 to 0 with row++.
// - Window mapping: coefficient k[i][j] multiplies the pixel at
//   (row-(SIZE-1)+i, col-(SIZE-1)+j) relative to the accepted pixel.
// - An output is produced when the accepted pixel has row >= SIZE-1 and col >= SIZE-1.
//   out_valid rises the next cycle (latency 1 cycle). No other positions produce output.
// - Arithmetic: acc = sum k*p, width PIX_W+COEF_W+clog2(SIZE*SIZE), no overflow.
//   Result = (acc + 2**(COEF_FRAC-1)) >> COEF_FRAC, round half up.
//   Result saturates to 2**PIX_W-1 if larger.
// - out_valid && !out_ready: out_pixel and out_valid hold stable and in_ready=0. No data is lost.
// - Frame end: the accepted pixel at row=IMG_H-1, col=IMG_W-1 wraps row/col to 0.
//   frame_done pulses the cycle its output is accepted by downstream.
// - Reload: if reload=1 while row=col=0 and out_valid=0, go to LOAD (idx=0) and
//   in_ready=0 that cycle. reload at any other time is ignored.
//   Without reload, the next frame reuses the kernel.
// - Reset mid-operation: abandons the frame and kernel, returns to the reset state the next cycle.
// TESTING
// 1. SIZE=3, IMG 8x8, identity kernel (centre 16384, rest 0), pixel=row*8+col
//    -> 36 outputs 9,10..14,17..54 in order, then one frame_done pulse.
// 2. Box kernel all 1820, constant input 90 -> every output 90 (1474200+8192>>14 = 90).
// 3. All coefficients 16384, input 255 -> every output saturates to 255.
// 4. Hold out_ready=0 for 5 cycles mid-frame -> in_ready=0 and out_pixel stable.
//    Total 36 outputs, no duplicates or drops.
// 5. Assert reset mid-frame, then reload kernel -> coef_ready=1 and out_valid=0 next cycle.
//    The following frame matches the golden model.
// 6. Two back-to-back frames without reload -> identical outputs, exactly one frame_done each.
//    reload at frame boundary -> LOAD, new kernel used.

Source files
------------

// File: rtl/gaussian_blur_stream.sv
// ----------------------------------------------------------------------------
// gaussian_blur_stream: streaming SIZE x SIZE fixed-point convolution, valid window positions only.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gaussian_blur_stream #(
  parameter int SIZE      = 5,
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int PIX_W     = 8,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              coef_valid_i,
  output logic              coef_ready_o,
  input  logic [COEF_W-1:0] coef_data_i,
  input  logic              reload_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PIX_W-1:0]  in_pixel_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PIX_W-1:0]  out_pixel_o,
  output logic              frame_done_o
);

  localparam int NCOEF = SIZE * SIZE;
  localparam int IDX_W = $clog2(NCOEF);
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int ACC_W = PIX_W + COEF_W + $clog2(NCOEF) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCOEF - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] EDGE_COL = COL_W'(SIZE - 1);
  localparam logic [ROW_W-1:0] EDGE_ROW = ROW_W'(SIZE - 1);
  localparam logic [ACC_W-1:0] HALF     = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic [ACC_W-1:0] PIX_MAX  = ACC_W'((1 << PIX_W) - 1);

  typedef enum logic [0:0] {LOAD = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic               coef_ready_q;
  logic               out_valid_q;
  logic [PIX_W-1:0]   out_pixel_q;
  logic               out_last_q;
  logic [COEF_W-1:0]  coef_q [NCOEF];
  logic [PIX_W-1:0]   lb_q   [SIZE-1][IMG_W];
  logic [PIX_W-1:0]   win_q  [SIZE][SIZE-1];

  logic [PIX_W-1:0]   col_pix [SIZE];
  logic [PIX_W-1:0]   win     [SIZE][SIZE];
  logic [ACC_W-1:0]   acc, rounded, shifted;
  logic [PIX_W-1:0]   result_d;
  logic               reload_take, pix_fire, win_full, frame_end;

  assign coef_ready_o = coef_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_pixel_o  = out_pixel_q;
  assign frame_done_o = out_valid_q && out_ready_i && out_last_q;

  assign reload_take = (state_q == RUN) && reload_i && (row_q == '0) && (col_q == '0) && !out_valid_q;
  assign in_ready_o  = (state_q == RUN) && !reload_take && (!out_valid_q || out_ready_i);
  assign pix_fire    = in_valid_i && in_ready_o;
  assign win_full    = (row_q >= EDGE_ROW) && (col_q >= EDGE_COL);
  assign frame_end   = (row_q == LAST_ROW) && (col_q == LAST_COL);

  // Newest column: current pixel at the bottom, older rows read from the line buffers above it.
  assign col_pix[SIZE-1] = in_pixel_i;
  for (genvar r = 0; r < SIZE - 1; r++) begin : g_lb_tap
    assign col_pix[SIZE-2-r] = lb_q[r][col_q];
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_win_row
    for (genvar j = 0; j < SIZE - 1; j++) begin : g_win_col
      assign win[i][j] = win_q[i][j];
    end
    assign win[i][SIZE-1] = col_pix[i];
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        acc = acc + ACC_W'(coef_q[i*SIZE+j]) * ACC_W'(win[i][j]);
      end
    end
    rounded  = acc + HALF;
    shifted  = rounded >> COEF_FRAC;
    result_d = (shifted > PIX_MAX) ? '1 : shifted[PIX_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      coef_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      out_last_q   <= 1'b0;
      for (int k = 0; k < NCOEF; k++) coef_q[k] <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (coef_valid_i && coef_ready_q) begin
            coef_q[idx_q] <= coef_data_i;
            if (idx_q == LAST_IDX) begin
              idx_q        <= '0;
              state_q      <= RUN;
              coef_ready_q <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        RUN: begin
          if (reload_take) begin
            state_q      <= LOAD;
            idx_q        <= '0;
            coef_ready_q <= 1'b1;
          end
        end
        default: state_q <= LOAD;
      endcase

      if (out_ready_i) out_valid_q <= 1'b0;
      if (pix_fire) begin
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
        if (win_full) begin
          out_valid_q <= 1'b1;
          out_pixel_q <= result_d;
          out_last_q  <= frame_end;
        end
      end
    end
  end

  // Pixel storage carries no reset; stale contents only feed positions that never emit.
  always_ff @(posedge clk_i) begin
    if (pix_fire) begin
      lb_q[0][col_q] <= in_pixel_i;
      for (int r = 1; r < SIZE - 1; r++) lb_q[r][col_q] <= lb_q[r-1][col_q];
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE - 1; j++) win_q[i][j] <= win[i][j+1];
      end
    end
  end

endmodule

`default_nettype wire
